// File: rtl/hazard_ctrl.sv
// Load-use / branch-flush / memory-wait hazard sequencer with a saturating stall counter.
// Controls respond in the same cycle; state, cnt, ret_state and stall_count are registered.
module hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int LU_STALL   = 1,
  parameter int BR_PENALTY = 2,
  parameter int CNT_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_Rt,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             EX_BranchTaken,
  input  logic             dmem_busy,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             Pipe_Freeze,
  output logic [1:0]       state,
  output logic [15:0]      stall_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LU_INIT = CNT_W'(LU_STALL - 1);
  localparam logic [CNT_W-1:0] BR_INIT = CNT_W'(BR_PENALTY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           cur, nxt, ret, ret_nxt, eff;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lu;

  assign lu = IDEX_MemRead && (IDEX_Rt != '0) &&
              ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));

  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    Pipe_Freeze = 1'b0;
    nxt         = cur;
    cnt_nxt     = cnt;
    ret_nxt     = ret;
    // Leaving MEM_WAIT behaves exactly like the interrupted state, so held hazards resume.
    eff         = (cur == MEM_WAIT && !dmem_busy) ? ret : cur;

    if (!rst) begin
      if (dmem_busy) begin
        Pipe_Freeze = 1'b1;
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        nxt         = MEM_WAIT;
        if (cur != MEM_WAIT) ret_nxt = cur;
      end else begin
        nxt = eff;
        case (eff)
          RUN: begin
            if (EX_BranchTaken) begin
              IFID_Flush = 1'b1;
              IDEX_Flush = 1'b1;
              if (BR_PENALTY > 1) begin
                cnt_nxt = BR_INIT;
                nxt     = FLUSH;
              end
            end else if (lu) begin
              PC_Write    = 1'b0;
              IFID_Write  = 1'b0;
              IDEX_Bubble = 1'b1;
              if (LU_STALL > 1) begin
                cnt_nxt = LU_INIT;
                nxt     = LOAD_STALL;
              end
            end
          end
          LOAD_STALL: begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
            cnt_nxt     = cnt - CNT_ONE;
            if (cnt == CNT_ONE) nxt = RUN;
          end
          FLUSH: begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
            cnt_nxt    = cnt - CNT_ONE;
            if (cnt == CNT_ONE) nxt = RUN;
          end
          default: nxt = RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= RUN;
      cnt         <= '0;
      ret         <= RUN;
      stall_count <= '0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
      ret <= ret_nxt;
      if (!PC_Write && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stimulus pushes per-cycle expectations, a negedge monitor checks.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst, mr, br, busy;
  logic [4:0]  rt, rs, rt2;

  logic        pcw_a, ifw_a, bub_a, iff_a, idf_a, frz_a;
  logic [1:0]  st_a;
  logic [15:0] sc_a;
  logic        pcw_b, ifw_b, bub_b, iff_b, idf_b, frz_b;
  logic [1:0]  st_b;
  logic [15:0] sc_b;

  hazard_ctrl #(.REG_W(5), .LU_STALL(1), .BR_PENALTY(2), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .IDEX_MemRead(mr), .IDEX_Rt(rt), .IFID_Rs(rs), .IFID_Rt(rt2),
    .EX_BranchTaken(br), .dmem_busy(busy), .PC_Write(pcw_a), .IFID_Write(ifw_a),
    .IDEX_Bubble(bub_a), .IFID_Flush(iff_a), .IDEX_Flush(idf_a), .Pipe_Freeze(frz_a),
    .state(st_a), .stall_count(sc_a));

  hazard_ctrl #(.REG_W(5), .LU_STALL(3), .BR_PENALTY(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .IDEX_MemRead(mr), .IDEX_Rt(rt), .IFID_Rs(rs), .IFID_Rt(rt2),
    .EX_BranchTaken(br), .dmem_busy(busy), .PC_Write(pcw_b), .IFID_Write(ifw_b),
    .IDEX_Bubble(bub_b), .IFID_Flush(iff_b), .IDEX_Flush(idf_b), .Pipe_Freeze(frz_b),
    .state(st_b), .stall_count(sc_b));

  always #5 clk = ~clk;

  // ctl order: {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, Pipe_Freeze}
  localparam logic [5:0] DEF = 6'b110000;
  localparam logic [5:0] BUB = 6'b001000;
  localparam logic [5:0] FLS = 6'b110110;
  localparam logic [5:0] FRZ = 6'b000001;

  typedef struct {
    string       nm;
    bit          on_b;
    bit          ctl_only;
    logic [23:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  wire [23:0] act_a = {pcw_a, ifw_a, bub_a, iff_a, idf_a, frz_a, st_a, sc_a};
  wire [23:0] act_b = {pcw_b, ifw_b, bub_b, iff_b, idf_b, frz_b, st_b, sc_b};

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [23:0] act;
      bit          bad;
      e   = sb.pop_front();
      act = e.on_b ? act_b : act_a;
      bad = e.ctl_only ? (act[23:18] !== e.v[23:18]) : (act !== e.v);
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s: got ctl=%b st=%0d cnt=%h, want ctl=%b st=%0d cnt=%h%s",
                 e.nm, act[23:18], act[17:16], act[15:0], e.v[23:18], e.v[17:16], e.v[15:0],
                 e.ctl_only ? " (ctl only)" : "");
      end
    end
  end

  task automatic cyc(input string nm, input logic r, input logic m, input logic [4:0] t,
                     input logic [4:0] s, input logic [4:0] s2, input logic b, input logic bz,
                     input bit onb, input bit co, input logic [5:0] ctl,
                     input logic [1:0] st, input logic [15:0] sc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; mr = m; rt = t; rs = s; rt2 = s2; br = b; busy = bz;
    e.nm = nm; e.on_b = onb; e.ctl_only = co; e.v = {ctl, st, sc};
    sb.push_back(e);
  endtask

  task automatic do_reset(input bit onb);
    cyc("reset_ctl", 1, 0, 0, 0, 0, 0, 0, onb, 1, DEF, 2'd0, 16'd0);
  endtask

  initial begin
    rst = 1'b1; mr = 1'b0; br = 1'b0; busy = 1'b0; rt = '0; rs = '0; rt2 = '0;

    // Reset state and load-use with single bubble
    do_reset(0);
    cyc("reset_state", 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 2'd0, 16'd0);
    cyc("lu_rs",       0, 1, 8, 8, 3, 0, 0, 0, 0, BUB, 2'd0, 16'd0);
    cyc("lu_rs_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 2'd0, 16'd1);
    cyc("lu_rt",       0, 1, 8, 3, 8, 0, 0, 0, 0, BUB, 2'd0, 16'd1);
    cyc("lu_rt_after", 0, 0, 8, 8, 8, 0, 0, 0, 0, DEF, 2'd0, 16'd2);
    cyc("lu_nomatch",  0, 1, 8, 3, 4, 0, 0, 0, 0, DEF, 2'd0, 16'd2);

    // Load to r0 never stalls
    do_reset(0);
    cyc("lu_r0",       0, 1, 0, 0, 0, 0, 0, 0, 0, DEF, 2'd0, 16'd0);
    cyc("lu_r0_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 2'd0, 16'd0);

    // Taken branch: two flush cycles, no stall counted
    do_reset(0);
    cyc("br_c0", 0, 0, 0, 0, 0, 1, 0, 0, 0, FLS, 2'd0, 16'd0);
    cyc("br_c1", 0, 0, 0, 0, 0, 1, 0, 0, 0, FLS, 2'd2, 16'd0);
    cyc("br_c2", 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 2'd0, 16'd0);

    // Three-bubble load-use, branch in LOAD_STALL ignored
    do_reset(1);
    cyc("lu3_c0", 0, 1, 9, 9, 0, 0, 0, 1, 0, BUB, 2'd0, 16'd0);
    cyc("lu3_c1", 0, 1, 9, 9, 0, 1, 0, 1, 0, BUB, 2'd1, 16'd1);
    cyc("lu3_c2", 0, 1, 9, 9, 0, 0, 0, 1, 0, BUB, 2'd1, 16'd2);
    cyc("lu3_c3", 0, 0, 0, 0, 0, 0, 0, 1, 0, DEF, 2'd0, 16'd3);

    // Memory wait interrupting LOAD_STALL resumes the remaining bubbles
    do_reset(1);
    cyc("luw_c0", 0, 1, 8, 8, 0, 0, 0, 1, 0, BUB, 2'd0, 16'd0);
    cyc("luw_c1", 0, 1, 8, 8, 0, 0, 1, 1, 0, FRZ, 2'd1, 16'd1);
    cyc("luw_c2", 0, 1, 8, 8, 0, 0, 1, 1, 0, FRZ, 2'd3, 16'd2);
    cyc("luw_c3", 0, 1, 8, 8, 0, 0, 1, 1, 0, FRZ, 2'd3, 16'd3);
    cyc("luw_c4", 0, 1, 8, 8, 0, 0, 0, 1, 0, BUB, 2'd3, 16'd4);
    cyc("luw_c5", 0, 1, 8, 8, 0, 0, 0, 1, 0, BUB, 2'd1, 16'd5);
    cyc("luw_c6", 0, 0, 0, 0, 0, 0, 0, 1, 0, DEF, 2'd0, 16'd6);

    // Busy beats branch; held branch flushes after the wait
    do_reset(0);
    cyc("bw_c0", 0, 0, 0, 0, 0, 1, 1, 0, 0, FRZ, 2'd0, 16'd0);
    cyc("bw_c1", 0, 0, 0, 0, 0, 1, 1, 0, 0, FRZ, 2'd3, 16'd1);
    cyc("bw_c2", 0, 0, 0, 0, 0, 1, 0, 0, 0, FLS, 2'd3, 16'd2);
    cyc("bw_c3", 0, 0, 0, 0, 0, 0, 0, 0, 0, FLS, 2'd2, 16'd2);
    cyc("bw_c4", 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 2'd0, 16'd2);

    // Reset in FLUSH forces defaults and clears state and counter
    do_reset(0);
    cyc("rf_c0", 0, 1, 7, 7, 0, 0, 0, 0, 0, BUB, 2'd0, 16'd0);
    cyc("rf_c1", 0, 0, 0, 0, 0, 1, 0, 0, 0, FLS, 2'd0, 16'd1);
    cyc("rf_c2", 1, 1, 7, 7, 0, 1, 1, 0, 0, DEF, 2'd2, 16'd1);
    cyc("rf_c3", 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 2'd0, 16'd0);

    // Saturation of the stall counter via a long memory wait
    do_reset(0);
    @(posedge clk);
    #1;
    rst = 1'b0; mr = 1'b0; br = 1'b0; busy = 1'b1;
    repeat (65533) @(posedge clk);
    cyc("sat_fffe",  0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, 2'd3, 16'hFFFE);
    cyc("sat_ffff",  0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, 2'd3, 16'hFFFF);
    cyc("sat_hold",  0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, 2'd3, 16'hFFFF);
    cyc("sat_exit",  0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 2'd3, 16'hFFFF);
    cyc("sat_run",   0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 2'd0, 16'hFFFF);

    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
